// File: rtl/sorted_serializer_if.sv
// ============================================================================
// Module : sorted_serializer_if
// Brief  : Frame-load and element-stream signal bundle of sorted_serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sorted_serializer_if #(
    parameter int DATA_W = 3
);
    logic              in_load;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_idx;
    logic              out_last;

    // Producer/consumer side (upstream sorter plus downstream sink)
    modport master (
        output in_load, a, b, c, d, out_ready,
        input  in_ready, out_data, out_valid, out_idx, out_last
    );

    modport slave (
        input  in_load, a, b, c, d, out_ready,
        output in_ready, out_data, out_valid, out_idx, out_last
    );
endinterface

`default_nettype wire

// File: rtl/sorted_serializer.sv
// ============================================================================
// Module : sorted_serializer
// Brief  : Two-slot frame buffer streaming 4-element sorted frames one beat per
//          cycle, with order checking, sticky error flags and a frame counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sorted_serializer #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    sorted_serializer_if.slave    bus,
    output logic                  order_err,
    output logic                  overflow,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [DATA_W-1:0] slot_q [2][4];
    logic              wptr_q, rptr_q, rptr_d;
    logic [1:0]        occ_q, occ_d, w_rem;
    logic [0:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d, w_first;
    logic              valid_q, valid_d, last_q, last_d;
    logic              err_q, ovf_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              w_in_ready, w_cap, w_drop, w_accept, w_retire, w_unsorted;
    logic              w_have_next;

    always_comb begin
        w_in_ready  = (occ_q != 2'd2) && !rst;
        w_cap       = bus.in_load && w_in_ready;
        w_drop      = bus.in_load && !w_in_ready;
        w_accept    = valid_q && bus.out_ready;
        w_retire    = w_accept && (idx_q == 2'd3);
        w_unsorted  = (bus.a > bus.b) || (bus.b > bus.c) || (bus.c > bus.d);
        occ_d       = occ_q + {1'b0, w_cap} - {1'b0, w_retire};
        rptr_d      = rptr_q ^ w_retire;
        w_rem       = occ_q - {1'b0, w_retire};
        w_have_next = (w_rem != 2'd0) || w_cap;
        // A frame captured this very cycle is not in its slot yet: bypass from the inputs
        w_first     = (w_rem != 2'd0) ? slot_q[rptr_d][0] : bus.a;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (w_have_next) begin
                    state_d = S_SEND;
                    valid_d = 1'b1;
                    idx_d   = 2'd0;
                    data_d  = w_first;
                    last_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    if (idx_q != 2'd3) begin
                        idx_d  = idx_q + 2'd1;
                        data_d = slot_q[rptr_q][idx_q + 2'd1];
                        last_d = (idx_q == 2'd2);
                    end else if (w_have_next) begin
                        idx_d  = 2'd0;
                        data_d = w_first;
                        last_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int e = 0; e < 4; e++) begin
                    slot_q[s][e] <= '0;
                end
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            occ_q   <= 2'd0;
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (w_cap) begin
                slot_q[wptr_q][0] <= bus.a;
                slot_q[wptr_q][1] <= bus.b;
                slot_q[wptr_q][2] <= bus.c;
                slot_q[wptr_q][3] <= bus.d;
                wptr_q            <= ~wptr_q;
                if (w_unsorted) begin
                    err_q <= 1'b1;
                end
            end
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
            if (w_retire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign order_err     = err_q;
    assign overflow      = ovf_q;
    assign frame_cnt     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sorted_serializer.sv
// ============================================================================
// Module : tb_sorted_serializer
// Brief  : Self-checking bench for sorted_serializer (vector table, directed
//          corner sequences and random traffic against a frame-queue model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sorted_serializer;
    localparam int DATA_W = 3;
    localparam int CNT_W  = 8;

    typedef logic [3:0][DATA_W-1:0] frame_t;

    typedef struct {
        bit     load;
        frame_t f;
        bit     rdy;
        bit     ev;
        int     ed;
        int     ei;
        bit     el;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             order_err, overflow;
    logic [CNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    sorted_serializer_if #(.DATA_W(DATA_W)) bus ();

    sorted_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .order_err (order_err),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of buffered frames, head is the one being streamed
    frame_t           mq[$];
    bit               m_valid;
    int               m_idx;
    bit               m_err, m_ovf;
    logic [CNT_W-1:0] m_cnt;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t fr(input int e0, input int e1, input int e2, input int e3);
        frame_t f;
        f[0] = e0[DATA_W-1:0];
        f[1] = e1[DATA_W-1:0];
        f[2] = e2[DATA_W-1:0];
        f[3] = e3[DATA_W-1:0];
        return f;
    endfunction

    function automatic vec_t mk(input bit ld, input frame_t f, input bit rdy,
                                input bit ev, input int ed, input int ei, input bit el);
        vec_t v;
        v.load = ld; v.f = f; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ei = ei; v.el = el;
        return v;
    endfunction

    task automatic model_edge(input bit ld, input frame_t f, input bit rdy, input bit r);
        bit acc, room;
        if (r) begin
            mq.delete();
            m_valid = 0; m_idx = 0; m_err = 0; m_ovf = 0; m_cnt = '0;
        end else begin
            acc  = m_valid && rdy;
            room = (mq.size() < 2);
            if (ld) begin
                if (room) begin
                    mq.push_back(f);
                    if (!(f[0] <= f[1] && f[1] <= f[2] && f[2] <= f[3])) m_err = 1;
                end else begin
                    m_ovf = 1;
                end
            end
            if (acc) begin
                if (m_idx == 3) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                    m_cnt = m_cnt + 1'b1;
                end else begin
                    m_idx++;
                end
            end
            m_valid = (mq.size() > 0);
        end
    endtask

    task automatic check_model();
        check("out_valid", int'(bus.out_valid), int'(m_valid));
        if (m_valid) begin
            check("out_data", int'(bus.out_data), int'(mq[0][m_idx]));
            check("out_idx", int'(bus.out_idx), m_idx);
            check("out_last", int'(bus.out_last), int'(m_idx == 3));
        end
        check("order_err", int'(order_err), int'(m_err));
        check("overflow", int'(overflow), int'(m_ovf));
        check("frame_cnt", int'(frame_cnt), int'(m_cnt));
    endtask

    // One clock: drive, check in_ready ahead of the edge, advance, check after it
    task automatic step(input bit ld, input frame_t f, input bit rdy, input bit r);
        bus.in_load   = ld;
        bus.a         = f[0];
        bus.b         = f[1];
        bus.c         = f[2];
        bus.d         = f[3];
        bus.out_ready = rdy;
        rst           = r;
        #1;
        check("in_ready", int'(bus.in_ready), int'(!r && mq.size() < 2));
        @(posedge clk);
        model_edge(ld, f, rdy, r);
        #1;
        check_model();
    endtask

    vec_t   tbl[12];
    frame_t z;
    frame_t f4;

    initial begin
        z = fr(0, 0, 0, 0);
        rst = 1'b1;
        bus.in_load = 0; bus.a = 0; bus.b = 0; bus.c = 0; bus.d = 0; bus.out_ready = 0;

        tbl[0]  = mk(1, fr(1, 3, 5, 7), 1, 1, 1, 0, 0);
        tbl[1]  = mk(0, z, 1, 1, 3, 1, 0);
        tbl[2]  = mk(0, z, 1, 1, 5, 2, 0);
        tbl[3]  = mk(0, z, 1, 1, 7, 3, 1);
        tbl[4]  = mk(0, z, 1, 0, 0, 0, 0);
        tbl[5]  = mk(1, fr(0, 2, 2, 6), 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, z, 0, 1, 0, 0, 0);
        tbl[7]  = mk(0, z, 0, 1, 0, 0, 0);
        tbl[8]  = mk(0, z, 1, 1, 2, 1, 0);
        tbl[9]  = mk(0, z, 1, 1, 2, 2, 0);
        tbl[10] = mk(0, z, 1, 1, 6, 3, 1);
        tbl[11] = mk(0, z, 1, 0, 0, 0, 0);

        // Reset state
        step(0, z, 0, 1);
        step(0, z, 0, 1);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_data", int'(bus.out_data), 0);
        check("rst_idx", int'(bus.out_idx), 0);
        check("rst_last", int'(bus.out_last), 0);
        check("rst_cnt", int'(frame_cnt), 0);

        // Single frame, then a stalled frame
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].load, tbl[i].f, tbl[i].rdy, 0);
            check($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_data", i), int'(bus.out_data), tbl[i].ed);
                check($sformatf("tbl%0d_idx", i), int'(bus.out_idx), tbl[i].ei);
                check($sformatf("tbl%0d_last", i), int'(bus.out_last), int'(tbl[i].el));
            end
            if (i == 4) begin
                check("t1_cnt", int'(frame_cnt), 1);
                check("t1_err", int'(order_err), 0);
            end
        end
        check("t2_cnt", int'(frame_cnt), 2);

        // Third back-to-back load hits a full buffer
        step(1, fr(4, 4, 4, 4), 0, 0);
        step(1, fr(5, 5, 5, 5), 0, 0);
        check("t3_in_ready_full", int'(bus.in_ready), 0);
        step(1, fr(6, 6, 6, 6), 0, 0);
        check("t3_overflow", int'(overflow), 1);
        for (int k = 0; k < 8; k++) begin
            check("t3_valid", int'(bus.out_valid), 1);
            check("t3_data", int'(bus.out_data), (k < 4) ? 4 : 5);
            step(0, z, 1, 0);
        end
        check("t3_cnt", int'(frame_cnt), 4);
        check("t3_idle", int'(bus.out_valid), 0);

        // Unsorted frame is flagged but emitted unchanged
        f4 = fr(7, 1, 2, 3);
        step(1, f4, 1, 0);
        check("t4_err", int'(order_err), 1);
        for (int k = 0; k < 4; k++) begin
            check("t4_data", int'(bus.out_data), int'(f4[k]));
            step(0, z, 1, 0);
        end
        step(1, fr(0, 1, 2, 3), 1, 0);
        for (int k = 0; k < 4; k++) step(0, z, 1, 0);
        check("t4_err_sticky", int'(order_err), 1);
        check("t4_cnt", int'(frame_cnt), 6);

        // Reset mid-frame with a second frame buffered
        step(1, fr(1, 2, 3, 4), 0, 0);
        step(1, fr(2, 3, 4, 5), 0, 0);
        step(0, z, 1, 0);
        check("t5_idx", int'(bus.out_idx), 1);
        step(0, z, 1, 1);
        check("t5_valid", int'(bus.out_valid), 0);
        check("t5_err", int'(order_err), 0);
        check("t5_ovf", int'(overflow), 0);
        check("t5_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        #1;
        check("t5_in_ready", int'(bus.in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            step(0, z, 1, 0);
            check("t5_quiet", int'(bus.out_valid), 0);
        end

        // Counter wrap
        for (int n = 0; n < 255; n++) begin
            step(1, fr(n % 8, n % 8, 7, 7), 1, 0);
            for (int k = 0; k < 4; k++) step(0, z, 1, 0);
        end
        check("t6_cnt255", int'(frame_cnt), 255);
        step(1, fr(0, 1, 1, 2), 1, 0);
        for (int k = 0; k < 4; k++) step(0, z, 1, 0);
        check("t6_wrap", int'(frame_cnt), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            frame_t rf;
            for (int e = 0; e < 4; e++) rf[e] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            step(bit'($urandom_range(0, 1)), rf, bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
